// File: rtl/dcache_write_buffer_if.sv
// rtl/dcache_write_buffer_if.sv - store, load-forward and memory-drain signals of the write buffer
interface dcache_write_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     full;
   logic                     rd_en;
   logic [ADDR_W-1:0]        rd_addr;
   logic                     rd_hit;
   logic [DATA_W-1:0]        rd_data;
   logic                     mem_req;
   logic [ADDR_W-1:0]        mem_addr;
   logic [DATA_W-1:0]        mem_wdata;
   logic                     mem_ack;
   logic                     empty;
   logic [$clog2(DEPTH):0]   count;

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr, mem_ack,
      output full, rd_hit, rd_data, mem_req, mem_addr, mem_wdata, empty, count
   );

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr, mem_ack,
      input  full, rd_hit, rd_data, mem_req, mem_addr, mem_wdata, empty, count
   );
endinterface

// File: rtl/dcache_write_buffer.sv
// rtl/dcache_write_buffer.sv - write-through store buffer with load forwarding and req/ack drain
// Optional in-place store merging into unlocked entries: WB_COALESCE_EN
module dcache_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic                   clk,
   input logic                   rst_n,
   dcache_write_buffer_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic {IDLE, REQ} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-3:0]   addr_q [DEPTH];
   logic [DATA_W-1:0]   data_q [DEPTH];
   logic [PW-1:0]       head_q, tail_q;
   logic [PW:0]         count_q;
   logic [PW-1:0]       slot [DEPTH];
   logic                live [DEPTH];
   logic                push, pop, full, empty;
   logic                fwd_hit;
   logic [DATA_W-1:0]   fwd_data;

   // slot[i] is the i-th oldest entry; live[i] says whether it holds a store
   for (genvar i = 0; i < DEPTH; i++) begin : g_order
      assign slot[i] = head_q + PW'(i);
      assign live[i] = (PW+1)'(i) < count_q;
   end

   assign full  = count_q == (PW+1)'(DEPTH);
   assign empty = count_q == '0;
   assign pop   = (state_q == REQ) && bus.mem_ack;

`ifdef WB_COALESCE_EN
   logic          coal_hit;
   logic [PW-1:0] coal_idx;

   always_comb begin
      coal_hit = 1'b0;
      coal_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live[i] && !(i == 0 && state_q == REQ) &&
             addr_q[slot[i]] == bus.wr_addr[ADDR_W-1:2]) begin
            coal_hit = bus.wr_en;
            coal_idx = slot[i];
         end
      end
   end

   assign push = bus.wr_en && !full && !coal_hit;
`else
   assign push = bus.wr_en && !full;
`endif

   // Oldest-to-youngest scan so the youngest match wins
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.rd_en && live[i] && addr_q[slot[i]] == bus.rd_addr[ADDR_W-1:2]) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[slot[i]];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!empty) state_d = REQ;
         REQ:     if (bus.mem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            addr_q[tail_q] <= bus.wr_addr[ADDR_W-1:2];
            data_q[tail_q] <= bus.wr_data;
            tail_q         <= tail_q + PW'(1);
         end
`ifdef WB_COALESCE_EN
         if (coal_hit) data_q[coal_idx] <= bus.wr_data;
`endif
         if (pop) head_q <= head_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.count     = count_q;
   assign bus.rd_hit    = fwd_hit;
   assign bus.rd_data   = fwd_data;
   assign bus.mem_req   = state_q == REQ;
   assign bus.mem_addr  = (state_q == REQ) ? {addr_q[head_q], 2'b00} : '0;
   assign bus.mem_wdata = (state_q == REQ) ? data_q[head_q] : '0;
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb/tb_dcache_write_buffer.sv - scoreboard bench for dcache_write_buffer
module tb_dcache_write_buffer;
   localparam int DEPTH = 4;

   typedef struct {
      logic [29:0] w;
      logic [31:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ent_t mq[$];
   ent_t exp_drain[$];
   bit   mreq = 1'b0;

   dcache_write_buffer_if #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) bus ();

   dcache_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of pending stores plus a "drain requested" flag
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         exp_drain.delete();
         mreq = 1'b0;
      end else begin
         bit pre_req, do_pop, was_full, merged;
         int n;
         pre_req  = mreq;
         n        = mq.size();
         was_full = (n == DEPTH);
         do_pop   = pre_req && bus.mem_ack;
         if (do_pop) void'(mq.pop_front());
         if (pre_req) mreq = !bus.mem_ack;
         else         mreq = (n != 0);
         merged = 1'b0;
         if (bus.wr_en) begin
`ifdef WB_COALESCE_EN
            for (int i = (pre_req && !do_pop) ? 1 : 0; i < mq.size(); i++) begin
               if (mq[i].w == bus.wr_addr[31:2]) begin
                  mq[i].d = bus.wr_data;
                  if (i < exp_drain.size()) exp_drain[i].d = bus.wr_data;
                  merged = 1'b1;
               end
            end
`endif
            if (!merged && !was_full) begin
               ent_t e;
               e.w = bus.wr_addr[31:2];
               e.d = bus.wr_data;
               mq.push_back(e);
               exp_drain.push_back(e);
            end
         end
      end
   end

   // Monitor: compares DUT outputs against the model away from the active edge
   always @(negedge clk) begin
      bit          e_hit;
      logic [31:0] e_data;
      chk("count", 64'(bus.count), 64'(mq.size()));
      chk("full", 64'(bus.full), 64'(mq.size() == DEPTH));
      chk("empty", 64'(bus.empty), 64'(mq.size() == 0));
      chk("mem_req", 64'(bus.mem_req), 64'(mreq));
      if (mreq && mq.size() > 0) begin
         chk("mem_addr_head", 64'(bus.mem_addr), 64'({mq[0].w, 2'b00}));
         chk("mem_wdata_head", 64'(bus.mem_wdata), 64'(mq[0].d));
      end
      if (bus.mem_req && bus.mem_ack) begin
         if (exp_drain.size() == 0) begin
            chk("drain_unexpected", 64'(1), 64'(0));
         end else begin
            ent_t e;
            e = exp_drain.pop_front();
            chk("drain_addr", 64'(bus.mem_addr), 64'({e.w, 2'b00}));
            chk("drain_data", 64'(bus.mem_wdata), 64'(e.d));
         end
      end
      e_hit  = 1'b0;
      e_data = '0;
      if (bus.rd_en) begin
         foreach (mq[i]) begin
            if (mq[i].w == bus.rd_addr[31:2]) begin
               e_hit  = 1'b1;
               e_data = mq[i].d;
            end
         end
      end
      chk("rd_hit", 64'(bus.rd_hit), 64'(e_hit));
      chk("rd_data", 64'(bus.rd_data), 64'(e_data));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_en   = 1'b0;
      bus.rd_addr = '0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      step();
      bus.wr_en   = 1'b0;
   endtask

   task automatic drain_all();
      int n;
      idle_inputs();
      bus.mem_ack = 1'b1;
      n = 0;
      while ((mq.size() != 0 || mreq) && n < 60) begin
         step();
         n++;
      end
      chk("drain_timeout", 64'(mq.size() != 0 || mreq), 64'(0));
      bus.mem_ack = 1'b0;
      step();
   endtask

   initial begin
      idle_inputs();
      bus.mem_ack = 1'b0;
      #12;
      chk("reset_count", 64'(bus.count), 64'(0));
      chk("reset_empty", 64'(bus.empty), 64'(1));
      chk("reset_full", 64'(bus.full), 64'(0));
      chk("reset_mem_req", 64'(bus.mem_req), 64'(0));
      chk("reset_mem_addr", 64'(bus.mem_addr), 64'(0));
      chk("reset_mem_wdata", 64'(bus.mem_wdata), 64'(0));
      step();
      rst_n = 1'b1;
      step();

      // Single store drained with ack tied high
      bus.mem_ack = 1'b1;
      store(32'h14, 32'hDEADBEEF);
      chk("t1_req_low_after_n", 64'(bus.mem_req), 64'(0));
      step();
      chk("t1_req", 64'(bus.mem_req), 64'(1));
      chk("t1_addr", 64'(bus.mem_addr), 64'(32'h14));
      chk("t1_data", 64'(bus.mem_wdata), 64'(32'hDEADBEEF));
      step();
      step();
      chk("t1_empty", 64'(bus.empty), 64'(1));
      chk("t1_count", 64'(bus.count), 64'(0));

      // Fill with ack low, fifth store dropped, then drain in order
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) store(32'(i * 4), 32'hA000_0000 + 32'(i));
      chk("t2_full", 64'(bus.full), 64'(1));
      store(32'h10, 32'hBADBAD00);
      chk("t2_count_after_drop", 64'(bus.count), 64'(4));
      drain_all();

      // Duplicate word address, forward youngest
      store(32'h20, 32'h11111111);
      store(32'h20, 32'h22222222);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 32'h22;
      #1;
      chk("t3_hit", 64'(bus.rd_hit), 64'(1));
      chk("t3_data", 64'(bus.rd_data), 64'(32'h22222222));
`ifdef WB_COALESCE_EN
      chk("t3_count", 64'(bus.count), 64'(1));
`else
      chk("t3_count", 64'(bus.count), 64'(2));
`endif
      step();
      drain_all();

      // Full in REQ: store and ack in the same cycle
      for (int i = 0; i < 4; i++) store(32'h40 + 32'(i * 4), 32'hC000_0000 + 32'(i));
      step();
      chk("t4_req", 64'(bus.mem_req), 64'(1));
      bus.wr_en   = 1'b1;
      bus.wr_addr = 32'h50;
      bus.wr_data = 32'h55555555;
      bus.mem_ack = 1'b1;
      step();
      bus.wr_en   = 1'b0;
      bus.mem_ack = 1'b0;
      chk("t4_count", 64'(bus.count), 64'(3));
      drain_all();

      // Asynchronous reset in the middle of a handshake
      for (int i = 0; i < 3; i++) store(32'h60 + 32'(i * 4), 32'hE000_0000 + 32'(i));
      step();
      chk("t5_req_before", 64'(bus.mem_req), 64'(1));
      #2;
      rst_n = 1'b0;
      bus.mem_ack = 1'b1;
      #1;
      chk("t5_req_async", 64'(bus.mem_req), 64'(0));
      chk("t5_count_async", 64'(bus.count), 64'(0));
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk("t5_no_stale", 64'(bus.mem_req), 64'(0));
      bus.mem_ack = 1'b0;

      // Load miss
      bus.rd_en   = 1'b1;
      bus.rd_addr = 32'h30;
      #1;
      chk("t6_hit", 64'(bus.rd_hit), 64'(0));
      chk("t6_data", 64'(bus.rd_data), 64'(0));
      step();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bus.wr_en   = ($urandom_range(0, 9) < 4);
         bus.wr_addr = {25'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00} >> 2;
         bus.wr_addr = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         bus.wr_data = $urandom;
         bus.rd_en   = $urandom_range(0, 1);
         bus.rd_addr = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         bus.mem_ack = ($urandom_range(0, 9) < 5);
         step();
      end
      drain_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
